// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int N_DEF = 4;
  localparam int M_DEF = 2;

  // Step counter width: must hold N-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for seq_restoring_divider.
// Optional macro DIV_SELFCHECK_EN adds the chk_err result flag.
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_by_zero;
`ifdef DIV_SELFCHECK_EN
  logic         chk_err;
`endif

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
`ifdef DIV_SELFCHECK_EN
    , input chk_err
`endif
  );

  // The divider itself.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
`ifdef DIV_SELFCHECK_EN
    , output chk_err
`endif
  );

endinterface

// File: rtl/seq_restoring_divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module div_step #(
  parameter int M = 2
) (
  input  logic [M-1:0] p_i,        // partial remainder, always < divisor
  input  logic         q_msb_i,    // next dividend bit to shift in
  input  logic [M-1:0] divisor_i,
  output logic [M-1:0] p_o,        // next partial remainder
  output logic         q_bit_o     // resolved quotient bit
);
  logic [M:0] trial;
  logic [M:0] diff;

  // The restored value is always < divisor, so it fits back into M bits.
  always_comb begin
    trial   = {p_i, q_msb_i};
    diff    = trial - {1'b0, divisor_i};
    q_bit_o = ~diff[M];
    p_o     = q_bit_o ? diff[M-1:0] : trial[M-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock behind valid/ready.
// Optional macro DIV_SELFCHECK_EN adds a reconstruction check flag (chk_err).
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus
);
  localparam int CW = cnt_width(N);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  p_q, p_d;      // partial remainder; becomes the remainder
  logic [N-1:0]  q_q, q_d;      // dividend shifts out while quotient shifts in
  logic [M-1:0]  dvs_q, dvs_d;
  logic          dbz_q, dbz_d;
  logic          rdy_q;
  logic          accept;
  logic [M-1:0]  step_p;
  logic          step_bit;

  div_step #(.M(M)) u_step (
    .p_i       (p_q),
    .q_msb_i   (q_q[N-1]),
    .divisor_i (dvs_q),
    .p_o       (step_p),
    .q_bit_o   (step_bit)
  );

  assign accept = (state_q == IDLE) && rdy_q && bus.in_valid;

  // Next-state and datapath update; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dvs_d = bus.divisor;
          if (bus.divisor != '0) begin
            state_d = CALC;
            cnt_d   = CW'(N - 1);
            p_d     = '0;
            q_d     = bus.dividend;
            dbz_d   = 1'b0;
          end else begin
            state_d = DONE;
            p_d     = '0;
            q_d     = '1;
            dbz_d   = 1'b1;
          end
        end
      end
      CALC: begin
        p_d = step_p;
        q_d = {q_q[N-2:0], step_bit};
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; in_ready is registered so it stays low during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
      rdy_q   <= (state_d == IDLE);
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = q_q;
  assign bus.remainder   = p_q;
  assign bus.div_by_zero = dbz_q;

`ifdef DIV_SELFCHECK_EN
  logic [N-1:0]   dvd_q;
  logic [N+M-1:0] recon;

  // Keep the original dividend so the result can be reconstructed in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dvd_q <= '0;
    else if (accept) dvd_q <= bus.dividend;
  end

  // quotient*divisor+remainder must give back the dividend for any nonzero divisor.
  always_comb begin
    recon       = (N+M)'(q_q) * (N+M)'(dvs_q) + (N+M)'(p_q);
    bus.chk_err = (state_q == DONE) && !dbz_q && (recon != (N+M)'(dvd_q));
  end
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed + exhaustive bench for seq_restoring_divider (N=4, M=2).
module tb_seq_restoring_divider;
  import div_pkg::*;

  localparam int N = 4;
  localparam int M = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.N(N), .M(M)) ifc ();

  seq_restoring_divider #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [N-1:0] dd;
    logic [M-1:0] dv;
    logic [N-1:0] exp_q;
    logic [M-1:0] exp_r;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Wait for in_ready, present operands for one edge, then count edges until out_valid.
  // lat = edges after the accepting edge before out_valid is seen.
  task automatic start_op(input logic [N-1:0] dd, input logic [M-1:0] dv, output int lat);
    int w;
    w = 0;
    while (!ifc.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", {31'd0, ifc.in_ready}, 32'd1);
    ifc.in_valid = 1'b1;
    ifc.dividend = dd;
    ifc.divisor  = dv;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    lat = 0;
    while (!ifc.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Complete the output handshake, optionally stalling with random out_ready.
  task automatic release_op(input bit rnd);
    bit r;
    for (int k = 0; k < 40; k++) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == 39) r = 1'b1;
      ifc.out_ready = r;
      @(posedge clk);
      @(negedge clk);
      if (r) break;
    end
    ifc.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [N-1:0] q_hold;
    logic [M-1:0] r_hold;

    vecs[0] = '{4'd9,  2'd3, 4'd3,  2'd0, 1'b0};
    vecs[1] = '{4'd15, 2'd2, 4'd7,  2'd1, 1'b0};
    vecs[2] = '{4'd1,  2'd3, 4'd0,  2'd1, 1'b0};
    vecs[3] = '{4'd5,  2'd0, 4'hF,  2'd0, 1'b1};
    vecs[4] = '{4'd14, 2'd3, 4'd4,  2'd2, 1'b0};
    vecs[5] = '{4'd0,  2'd1, 4'd0,  2'd0, 1'b0};
    vecs[6] = '{4'd15, 2'd3, 4'd5,  2'd0, 1'b0};
    vecs[7] = '{4'd8,  2'd1, 4'd8,  2'd0, 1'b0};
    vecs[8] = '{4'd15, 2'd1, 4'hF,  2'd0, 1'b0};
    vecs[9] = '{4'd0,  2'd0, 4'hF,  2'd0, 1'b1};

    ifc.in_valid  = 1'b0;
    ifc.dividend  = '0;
    ifc.divisor   = '0;
    ifc.out_ready = 1'b0;

    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {31'd0, ifc.in_ready},    32'd0);
    check("rst_out_valid", {31'd0, ifc.out_valid},   32'd0);
    check("rst_quotient",  {28'd0, ifc.quotient},    32'd0);
    check("rst_remainder", {30'd0, ifc.remainder},   32'd0);
    check("rst_dbz",       {31'd0, ifc.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, ifc.in_ready}, 32'd1);

    // Directed table: results, latency and return to IDLE.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].dd, vecs[i].dv, lat);
      $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", vecs[i].dd, vecs[i].dv,
               ifc.quotient, ifc.remainder, ifc.div_by_zero, lat);
      check("tbl_latency", lat, vecs[i].exp_dbz ? 32'd0 : N);
      check("tbl_quotient",  {28'd0, ifc.quotient},    {28'd0, vecs[i].exp_q});
      check("tbl_remainder", {30'd0, ifc.remainder},   {30'd0, vecs[i].exp_r});
      check("tbl_dbz",       {31'd0, ifc.div_by_zero}, {31'd0, vecs[i].exp_dbz});
      check("tbl_busy_ready", {31'd0, ifc.in_ready},   32'd0);
      release_op(1'b0);
      check("tbl_out_drop",  {31'd0, ifc.out_valid},   32'd0);
      check("tbl_idle_ready", {31'd0, ifc.in_ready},   32'd1);
    end

    // Busy/backpressure: in_valid with other operands during CALC and a stalled DONE.
    ifc.in_valid = 1'b1;
    ifc.dividend = 4'd9;
    ifc.divisor  = 2'd3;
    @(posedge clk);
    @(negedge clk);
    ifc.dividend = 4'd7;
    ifc.divisor  = 2'd1;
    lat = 0;
    while (!ifc.out_valid && lat < 50) begin
      check("calc_in_ready", {31'd0, ifc.in_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, N);
    q_hold = ifc.quotient;
    r_hold = ifc.remainder;
    check("bp_quotient", {28'd0, q_hold}, 32'd3);
    check("bp_remainder", {30'd0, r_hold}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      $display("stall %0d: out_valid=%0d q=%0d r=%0d in_ready=%0d", k, ifc.out_valid,
               ifc.quotient, ifc.remainder, ifc.in_ready);
      check("bp_out_valid", {31'd0, ifc.out_valid},   32'd1);
      check("bp_q_stable",  {28'd0, ifc.quotient},    32'd3);
      check("bp_r_stable",  {30'd0, ifc.remainder},   32'd0);
      check("bp_dbz",       {31'd0, ifc.div_by_zero}, 32'd0);
      check("bp_in_ready",  {31'd0, ifc.in_ready},    32'd0);
    end
    ifc.in_valid = 1'b0;
    release_op(1'b0);
    check("bp_idle_ready", {31'd0, ifc.in_ready}, 32'd1);
    start_op(4'd7, 2'd2, lat);
    $display("op 7/2 after stall -> q=%0d r=%0d", ifc.quotient, ifc.remainder);
    check("bp_next_q", {28'd0, ifc.quotient},  32'd3);
    check("bp_next_r", {30'd0, ifc.remainder}, 32'd1);
    release_op(1'b0);

    // Reset during CALC of 14/3: outputs return to reset values at once.
    ifc.in_valid = 1'b1;
    ifc.dividend = 4'd14;
    ifc.divisor  = 2'd3;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("mid-calc reset: out_valid=%0d q=%0d r=%0d in_ready=%0d", ifc.out_valid,
             ifc.quotient, ifc.remainder, ifc.in_ready);
    check("mrst_out_valid", {31'd0, ifc.out_valid},   32'd0);
    check("mrst_quotient",  {28'd0, ifc.quotient},    32'd0);
    check("mrst_remainder", {30'd0, ifc.remainder},   32'd0);
    check("mrst_dbz",       {31'd0, ifc.div_by_zero}, 32'd0);
    check("mrst_in_ready",  {31'd0, ifc.in_ready},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(4'd14, 2'd3, lat);
    $display("op 14/3 after reset -> q=%0d r=%0d", ifc.quotient, ifc.remainder);
    check("mrst_lat", lat, N);
    check("mrst_q", {28'd0, ifc.quotient},  32'd4);
    check("mrst_r", {30'd0, ifc.remainder}, 32'd2);
    release_op(1'b0);

    // Exhaustive nonzero-divisor sweep with random output stalls.
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 1; dv < 4; dv++) begin
        start_op(4'(dd), 2'(dv), lat);
        $display("sweep %0d/%0d -> q=%0d r=%0d", dd, dv, ifc.quotient, ifc.remainder);
        check("sweep_identity", 32'(ifc.quotient) * 32'(dv) + 32'(ifc.remainder), 32'(dd));
        check("sweep_rem_lt", {31'd0, (32'(ifc.remainder) < 32'(dv))}, 32'd1);
`ifdef DIV_SELFCHECK_EN
        check("sweep_chk_err", {31'd0, ifc.chk_err}, 32'd0);
`endif
        release_op(1'b1);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative restoring divider; the inverse operation of the team's 2x2 Vedic multiplier.
- Recovers quotient and remainder from a product-width dividend and a multiplier-width divisor.
- Resolves one quotient bit per clock.
- Sits behind valid/ready handshakes so it can be chained after multiplier datapaths, e.g. for result checking or inverse scaling.

Parameters:
- N, 4, dividend and quotient width; must be >= 2.
- M, 2, divisor and remainder width; must be 1 <= M <= N.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- dividend  input  N  unsigned dividend.
- divisor  input  M  unsigned divisor.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- quotient  output  N  unsigned quotient.
- remainder  output  M  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: in_ready=0 while rst_n low, 1 in the first cycle after release. out_valid=0, quotient=0, remainder=0, div_by_zero=0. State=IDLE, step counter=0.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register operands.
  - divisor!=0: go to CALC, counter=N-1, partial remainder P (M+1 bits)=0, Q=dividend.
  - divisor==0: go straight to DONE with quotient={N{1}}, remainder=0, div_by_zero=1.
- CALC: in_ready=0. Each cycle:
  - T={P[M-1:0],Q[N-1]}; D=T-{1'b0,divisor} (M+1 bits).
  - If D is non-negative (MSB=0): P=D, shift Q left inserting 1.
  - Else: P=T, shift Q left inserting 0.
  - At counter==0 go to DONE; otherwise decrement.
- DONE: out_valid=1. quotient/remainder/div_by_zero stay stable until out_ready. On out_valid&&out_ready go to IDLE; out_valid drops next cycle.
- Latency: handshake accepted at edge t → out_valid high from edge t+N+1 (N CALC cycles). Divide-by-zero: out_valid at t+1.
- Throughput: at most one operation per N+2 cycles. No overlap; in_ready=0 throughout CALC and DONE.
- Arithmetic: remainder < divisor always; quotient*divisor+remainder == dividend for all divisor!=0.
- Backpressure: out_ready=0 in DONE holds all outputs unchanged indefinitely.
- Inputs while busy: in_valid asserted during CALC/DONE is ignored; the operands are not captured.
- Reset mid-operation: rst_n low at any time immediately forces IDLE and reset values; no partial result is ever presented.
- Outputs are registered; no combinational path from inputs to outputs except in_ready from state.

Optional Feature:
- Macro: DIV_SELFCHECK_EN.
- Defined:
  - Adds output chk_err (1 bit, reset 0).
  - In DONE, with div_by_zero=0, computes quotient*divisor+remainder combinationally and compares it to the registered dividend.
  - chk_err=1 on mismatch, valid only while out_valid=1, cleared on leaving DONE.
- Undefined: no chk_err port, no multiplier logic; behaviour otherwise identical.

Decomposition:
- Package div_pkg:
  - State enum div_state_t {IDLE, CALC, DONE}.
  - Default widths N_DEF=4, M_DEF=2.
  - Helper function for the counter width $clog2(N).
- Sub-module div_step: combinational single restoring step.
  - In: P, Q MSB, divisor.
  - Out: next P, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan:
- Basic: dividend=9, divisor=3 → after N+1 cycles quotient=3, remainder=0, div_by_zero=0.
- Remainder: dividend=15, divisor=2 → quotient=7, remainder=1. Dividend=1, divisor=3 → quotient=0, remainder=1.
- Zero divisor: dividend=5, divisor=0 → out_valid next cycle, quotient=4'hF, remainder=0, div_by_zero=1.
- Backpressure and busy: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, a new in_valid is ignored. Raise out_ready → IDLE, in_ready=1, next operand accepted.
- Reset mid-CALC: assert rst_n low at cycle 2 of a 14/3 divide → all outputs at reset values immediately. After release, 14/3 gives quotient=4, remainder=2.
- Exhaustive: all 16x3 nonzero pairs with random out_ready → quotient*divisor+remainder==dividend and remainder<divisor. With DIV_SELFCHECK_EN defined, chk_err stays 0 throughout.
